// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg
//   Shared definitions for the VGA scan-out block: nominal 640x480@60 timing,
//   the RGB332 transparent key, the per-pixel control word carried down the
//   delay line, and the RGB332 -> RGB888 expansion function.
package vga_scan_pkg;

    // 640x480@60 timing, 25.175 MHz pixel clock
    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;

    // Colour key the sprite reader treats as "no pixel"
    localparam logic [7:0] RGB332_TRANSPARENT = 8'hE3;

    // Per-pixel control word; sync polarities stored as they appear on the pins
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } scan_ctl_t;

    localparam scan_ctl_t SCAN_CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication keeps full-scale codes at 255 and zero at 0
    function automatic rgb888_t rgb332_expand(input logic [7:0] c);
        rgb888_t o;
        o.r = {c[7:5], c[7:5], c[7:6]};
        o.g = {c[4:2], c[4:2], c[4:3]};
        o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Free-running horizontal/vertical scan counters with the undelayed
//   active/sync decode and the start-of-vertical-blank frame tick.
//
// Ports
//   clk        in   pixel clock
//   rst        in   asynchronous, active-high reset
//   h_cnt      out  10-bit column counter, 0..H_TOTAL-1
//   v_cnt      out  10-bit line counter, 0..V_TOTAL-1
//   raw_ctl    out  active/hs_n/vs_n decoded from the current counters
//   frame_tick out  high for the single cycle at h_cnt=0, v_cnt=V_ACTIVE
module vga_timing
    import vga_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FP     = H_FP_640,
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BP     = H_BP_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FP     = V_FP_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BP     = V_BP_480
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output scan_ctl_t  raw_ctl,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        raw_ctl        = SCAN_CTL_IDLE;
        raw_ctl.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw_ctl.hs_n   = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        raw_ctl.vs_n   = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    end

    // Decoded straight from the counters so game logic sees it with no delay
    assign frame_tick = (h_cnt == 10'd0) && (v_cnt == V_ACT);

endmodule

// File: rtl/vga_scan.sv
// vga_scan
//   VGA scan-out: drives scan coordinates to an external sprite reader,
//   delays the sync/active decode to line up with the reader's PIPE-cycle
//   latency, then registers the selected colour (blank / sprite / background)
//   expanded from RGB332 to the 8-bit DAC channels.
//
// Ports
//   clk            in   pixel clock
//   rst            in   asynchronous, active-high reset
//   pixel_x/y      out  current scan column/line (the counters themselves)
//   sprite_data    in   RGB332 sprite colour, valid PIPE cycles after pixel_x/y
//   sprite_visible in   sprite opaque flag, same timing as sprite_data
//   bg_color       in   RGB332 background colour, sampled every cycle
//   vga_r/g/b      out  DAC channels, PIPE+1 cycles after the coordinate
//   vga_hs/vs      out  active-low syncs, same latency as colour
//   vga_blank_n    out  high during active video, same latency as colour
//   vga_sync_n     out  tied low
//   frame_tick     out  one-cycle pulse at the start of vertical blank
//
// PIPE must be at least 1.
module vga_scan
    import vga_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FP     = H_FP_640,
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BP     = H_BP_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FP     = V_FP_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BP     = V_BP_480,
    parameter int PIPE     = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    input  logic [7:0] sprite_data,
    input  logic       sprite_visible,
    input  logic [7:0] bg_color,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       frame_tick
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    scan_ctl_t  ctl_p0;
    scan_ctl_t  ctl_p1 [PIPE];
    scan_ctl_t  ctl_aligned;
    logic [7:0] pix_sel;
    scan_ctl_t  ctl_p2;
    rgb888_t    rgb_p2;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .raw_ctl    (ctl_p0),
        .frame_tick (frame_tick)
    );

    // The counters are already registers, so the reader sees them unmodified
    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

    // ---- stage p0 -> p1: PIPE-deep delay matching the sprite reader ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                ctl_p1[i] <= SCAN_CTL_IDLE;
            end
        end else begin
            ctl_p1[0] <= ctl_p0;
            for (int i = 1; i < PIPE; i++) begin
                ctl_p1[i] <= ctl_p1[i-1];
            end
        end
    end

    assign ctl_aligned = ctl_p1[PIPE-1];

    // Blanking overrides everything so a sprite can never leak into the porches
    always_comb begin
        pix_sel = 8'h00;
        if (ctl_aligned.active) begin
            pix_sel = sprite_visible ? sprite_data : bg_color;
        end
    end

    // ---- stage p1 -> p2: output register, colour and syncs together ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_p2 <= SCAN_CTL_IDLE;
            rgb_p2 <= '0;
        end else begin
            ctl_p2 <= ctl_aligned;
            rgb_p2 <= rgb332_expand(pix_sel);
        end
    end

    assign vga_r       = rgb_p2.r;
    assign vga_g       = rgb_p2.g;
    assign vga_b       = rgb_p2.b;
    assign vga_hs      = ctl_p2.hs_n;
    assign vga_vs      = ctl_p2.vs_n;
    assign vga_blank_n = ctl_p2.active;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan
//   Self-checking bench for vga_scan using a reduced raster so whole frames
//   fit in a short run. A cycle-indexed model derives the expected raster
//   position, sync/blank levels and colour from plain arithmetic on the
//   number of clock edges since reset release.
module tb_vga_scan;

    localparam int HA   = 16;
    localparam int HF   = 2;
    localparam int HS   = 3;
    localparam int HB   = 4;
    localparam int VA   = 8;
    localparam int VF   = 2;
    localparam int VS   = 2;
    localparam int VB   = 3;
    localparam int PIPE = 2;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] sprite_data;
    logic       sprite_visible;
    logic [7:0] bg_color;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    // Measurements gathered by run()
    int hs_fall1, hs_fall2, hs_rise1;
    int vs_fall1, vs_fall2, vs_rise1;
    int ticks, first_hs_low;

    vga_scan #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIPE     (PIPE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .sprite_data    (sprite_data),
        .sprite_visible (sprite_visible),
        .bg_color       (bg_color),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .vga_hs         (vga_hs),
        .vga_vs         (vga_vs),
        .vga_blank_n    (vga_blank_n),
        .vga_sync_n     (vga_sync_n),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // RGB332 channel to 8 bits by scaling: 3-bit field spans 0..255 via 36*a + a/2
    function automatic int scale3(input int a);
        return 36 * a + a / 2;
    endfunction

    function automatic int scale2(input int a);
        return 85 * a;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_r"},       -1, 32'(vga_r),       32'd0);
        chk({tag, "_g"},       -1, 32'(vga_g),       32'd0);
        chk({tag, "_b"},       -1, 32'(vga_b),       32'd0);
        chk({tag, "_hs"},      -1, 32'(vga_hs),      32'd1);
        chk({tag, "_vs"},      -1, 32'(vga_vs),      32'd1);
        chk({tag, "_blank_n"}, -1, 32'(vga_blank_n), 32'd0);
        chk({tag, "_tick"},    -1, 32'(frame_tick),  32'd0);
        chk({tag, "_px"},      -1, 32'(pixel_x),     32'd0);
        chk({tag, "_py"},      -1, 32'(pixel_y),     32'd0);
    endtask

    // Assert reset asynchronously mid-cycle, hold 5 clocks, release on a negedge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset({tag, "_async"});
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset({tag, "_hold"});
        rst = 1'b0;
        #1;
    endtask

    // Cycle k = k rising edges after reset release. Checks outputs for cycle k,
    // then drives the sprite-reader inputs sampled at the end of cycle k.
    // mode 0: random; 1: bg=1C, random sprite; 2: opaque FF only at pixel (0,0);
    // 3: opaque E3 everywhere.
    task automatic run(input int n, input int mode);
        logic [7:0] p_sd;
        logic [7:0] p_bg;
        logic       p_sv;
        logic       last_hs;
        logic       last_vs;
        p_sd = 8'h00; p_bg = 8'h00; p_sv = 1'b0;
        last_hs = 1'b1; last_vs = 1'b1;
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
        vs_fall1 = -1; vs_fall2 = -1; vs_rise1 = -1;
        ticks = 0; first_hs_low = -1;
        for (int k = 0; k < n; k++) begin
            int ph, pv, c, h, v;
            logic act, ehs, evs;
            logic [7:0] col;
            ph = k % HT;
            pv = (k / HT) % VT;
            chk("pixel_x",    k, 32'(pixel_x),    32'(ph));
            chk("pixel_y",    k, 32'(pixel_y),    32'(pv));
            chk("frame_tick", k, 32'(frame_tick), 32'(ph == 0 && pv == VA));

            c = k - PIPE - 1;
            act = 1'b0; ehs = 1'b1; evs = 1'b1;
            if (c >= 0) begin
                h = c % HT;
                v = (c / HT) % VT;
                act = (h < HA) && (v < VA);
                ehs = !(h >= HA + HF && h < HA + HF + HS);
                evs = !(v >= VA + VF && v < VA + VF + VS);
            end
            col = act ? (p_sv ? p_sd : p_bg) : 8'h00;
            chk("vga_r",       k, 32'(vga_r),       32'(scale3(int'(col[7:5]))));
            chk("vga_g",       k, 32'(vga_g),       32'(scale3(int'(col[4:2]))));
            chk("vga_b",       k, 32'(vga_b),       32'(scale2(int'(col[1:0]))));
            chk("vga_hs",      k, 32'(vga_hs),      32'(ehs));
            chk("vga_vs",      k, 32'(vga_vs),      32'(evs));
            chk("vga_blank_n", k, 32'(vga_blank_n), 32'(act));
            chk("vga_sync_n",  k, 32'(vga_sync_n),  32'd0);

            if (mode == 2 && act && (c % FRAME) == 0) begin
                chk("latency_r", k, 32'(vga_r), 32'd255);
                chk("latency_g", k, 32'(vga_g), 32'd255);
                chk("latency_b", k, 32'(vga_b), 32'd255);
            end
            if (mode == 3 && act) begin
                chk("e3_r", k, 32'(vga_r), 32'd255);
                chk("e3_g", k, 32'(vga_g), 32'd0);
                chk("e3_b", k, 32'(vga_b), 32'd255);
            end
            if (mode == 1 && act && !p_sv) begin
                chk("bg1c_g", k, 32'({vga_r, vga_g, vga_b}), 32'h00FF00);
            end

            if (frame_tick) ticks++;
            if (!vga_hs && first_hs_low < 0) first_hs_low = k;
            if (last_hs && !vga_hs) begin
                if (hs_fall1 < 0) hs_fall1 = k;
                else if (hs_fall2 < 0) hs_fall2 = k;
            end
            if (!last_hs && vga_hs && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = k;
            if (last_vs && !vga_vs) begin
                if (vs_fall1 < 0) vs_fall1 = k;
                else if (vs_fall2 < 0) vs_fall2 = k;
            end
            if (!last_vs && vga_vs && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = k;
            last_hs = vga_hs;
            last_vs = vga_vs;

            case (mode)
                1: begin
                    bg_color       = 8'h1C;
                    sprite_visible = 1'($urandom);
                    sprite_data    = 8'($urandom);
                end
                2: begin
                    bg_color       = 8'($urandom);
                    sprite_data    = 8'hFF;
                    sprite_visible = (k >= PIPE) && (((k - PIPE) % FRAME) == 0);
                end
                3: begin
                    bg_color       = 8'($urandom);
                    sprite_data    = 8'hE3;
                    sprite_visible = 1'b1;
                end
                default: begin
                    bg_color       = 8'($urandom);
                    sprite_data    = 8'($urandom);
                    sprite_visible = 1'($urandom);
                end
            endcase
            p_sd = sprite_data;
            p_bg = bg_color;
            p_sv = sprite_visible;

            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst            = 1'b1;
        sprite_data    = 8'h00;
        sprite_visible = 1'b0;
        bg_color       = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        #1;

        // Free run over two frames with random colours
        run(2 * FRAME + 10, 0);
        chk("hs_period",    -1, 32'(hs_fall2 - hs_fall1), 32'(HT));
        chk("hs_low_width", -1, 32'(hs_rise1 - hs_fall1), 32'(HS));
        chk("vs_period",    -1, 32'(vs_fall2 - vs_fall1), 32'(FRAME));
        chk("vs_low_width", -1, 32'(vs_rise1 - vs_fall1), 32'(VS * HT));
        chk("tick_count",   -1, 32'(ticks),               32'd2);
        chk("first_hs_low", -1, 32'(first_hs_low),        32'(HA + HF + PIPE + 1));

        do_reset("rst1");
        run(FRAME + 20, 1);

        do_reset("rst2");
        run(FRAME + 20, 2);

        // Stop mid-frame inside the active area, then reset there
        do_reset("rst3");
        run((VA / 2) * HT + HA / 2, 3);
        chk("mid_px", -1, 32'(pixel_x), 32'(HA / 2));
        chk("mid_py", -1, 32'(pixel_y), 32'(VA / 2));
        chk("mid_blank_n", -1, 32'(vga_blank_n), 32'd1);
        do_reset("mid");
        run(3 * HT, 0);
        chk("mid_first_hs_low", -1, 32'(first_hs_low), 32'(HA + HF + PIPE + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 Parameter PIPE, default 2, sprite-path latency in clk cycles, from pixel coordinate to sprite_data/sprite_visible.
REQ-006 clk  input  1  pixel clock (25.175 MHz nominal).
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 pixel_x  output  10  current scan column, fed to the sprite reader's current_pixel_x.
REQ-009 pixel_y  output  10  current scan line, fed to the sprite reader's current_pixel_y.
REQ-010 sprite_data  input  8  RGB332 sprite colour returned by the sprite reader.
REQ-011 sprite_visible  input  1  sprite pixel opaque flag returned by the sprite reader.
REQ-012 bg_color  input  8  RGB332 background colour, sampled every cycle.
REQ-013 vga_r, vga_g, vga_b  output  8 each  DAC colour channels.
REQ-014 vga_hs, vga_vs  output  1 each  active-low sync pulses.
REQ-015 vga_blank_n  output  1  high during active video.
REQ-016 vga_sync_n  output  1  constant 0.
REQ-017 frame_tick  output  1  one-cycle pulse per frame for game logic.

Function
REQ-018 The block SHALL keep h_cnt counting 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters = 800) and wrapping to 0.
REQ-019 The block SHALL increment v_cnt when h_cnt wraps, counting 0..V_TOTAL-1 (525) and wrapping to 0 when both counters wrap together.
REQ-020 pixel_x/pixel_y SHALL equal h_cnt/v_cnt directly, registered, so the sprite reader sees coordinates at cycle t.
REQ-021 Raw active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-022 Raw hs is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
REQ-023 Raw vs is low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
REQ-024 Raw active, hs and vs SHALL pass through a PIPE-stage shift register, so vga_hs/vga_vs/vga_blank_n align with the sprite data for coordinate t at cycle t+PIPE.
REQ-025 Output colour, registered, one further cycle after the aligned point:
  - if delayed active=0: all channels 0;
  - else if sprite_visible=1: sprite_data;
  - else: bg_color.
  Sync/blank SHALL receive the same extra stage, for total output latency PIPE+1 from coordinate.
REQ-026 RGB332 expansion SHALL be r={c[7:5],c[7:5],c[7:6]}, g={c[4:2],c[4:2],c[4:3]}, b={c[1:0],c[1:0],c[1:0],c[1:0]}.
REQ-027 frame_tick SHALL pulse for exactly one cycle when h_cnt=0 and v_cnt=V_ACTIVE (start of vertical blank), undelayed.
REQ-028 Counter widths SHALL be 10 bits; parameters requiring totals >1023 are unsupported.

Reset
REQ-029 On rst, the block SHALL clear h_cnt, v_cnt, pixel_x, pixel_y and every pipeline stage to the inactive state (hs=1, vs=1, active=0).
REQ-030 During reset the outputs SHALL be: vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_tick=0.
REQ-031 On rst deassertion, scanning SHALL restart at (0,0).
REQ-032 Reset mid-frame SHALL abandon the frame, with no partial sync pulse beyond the reset edge.

Structure
REQ-033 A shared package SHALL hold the 640x480@60 timing constants, the RGB332 transparent value 8'hE3 and the expansion function.
REQ-034 One sub-module, vga_timing (counters, raw sync/active, frame_tick), is natural; the delay line and colour mux stay in vga_scan.

Verification
REQ-035 Free-run after reset: vga_hs period = 800 clks, low width = 96; vga_vs period = 420000 clks, low width = 1600.
REQ-036 Latency: force sprite_visible=1 and sprite_data=8'hFF only for pixel (0,0) -> vga_r/g/b=255 exactly at cycle PIPE+1 after pixel_x=0,pixel_y=0, and bg elsewhere.
REQ-037 bg_color=8'h1C, sprite_visible=0 -> active pixels give g=255, r=0, b=0; blank intervals give 0,0,0 even with sprite_visible=1.
REQ-038 frame_tick: pulses once per 420000 cycles, coincident with pixel_y=480, pixel_x=0.
REQ-039 Assert rst at pixel (300,200) for 5 cycles -> outputs at reset values immediately; after release pixel_x=0,pixel_y=0 and the first hs low at 656+PIPE+1 cycles.
REQ-040 Expansion: sprite_data=8'hE3 with visible=1 -> r=255, g=0, b=255.
